uart_tx_arbiter: RTL and testbench

Shares the single UART transmitter among NUM_REQ requesters, e.g. the threshold echo path, sensor telemetry and fault reporting. Each requester posts a 1- or 2-byte message. The arbiter grants requesters round-robin, latches the message and sequences its bytes into the uart start_tx/data_tx/idle_ready_tx handshake, LS byte first. It sits between the requesters and the uart instance and replaces direct start_tx drivers.

---
 rtl/uart_tx_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
// Shares one UART transmitter among NUM_REQ requesters. Requesters are
// granted round-robin; the granted 1- or 2-byte message is latched and its
// bytes are handed to the uart one at a time, LS byte first, through the
// start_tx / data_tx / idle_ready_tx handshake.
//
// Build option: define TX_FRAME_EN to prefix every message with a header
// byte 8'h30 + requester index (ASCII digit). Without it, only payload
// bytes are sent.
//
// PTR_W must equal clog2(NUM_REQ); NUM_REQ is expected in 2..8.

module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0]      req_two_byte,
  input  logic [16*NUM_REQ-1:0]   req_data,
  input  logic                    idle_ready_tx,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      done,
  output logic                    busy,
  output logic                    start_tx,
  output logic [7:0]              data_tx
);

  typedef enum logic [1:0] {IDLE, SEND, BUF, DONE} state_t;

  localparam logic [PTR_W:0]   NUM_REQ_W = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(NUM_REQ - 1);

  // Registered state
  state_t               r_state;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [PTR_W-1:0]     r_owner;
  logic [15:0]          r_msg;
  logic                 r_two;
  logic [1:0]           r_idx;
  logic [NUM_REQ-1:0]   r_grant;
  logic [NUM_REQ-1:0]   r_done;
  logic                 r_busy;
  logic                 r_start;
  logic [7:0]           r_data_tx;

  // Next-state values
  state_t               w_state_next;
  logic [PTR_W-1:0]     w_rr_ptr_next;
  logic [PTR_W-1:0]     w_owner_next;
  logic [15:0]          w_msg_next;
  logic                 w_two_next;
  logic [1:0]           w_idx_next;
  logic [NUM_REQ-1:0]   w_grant_next;
  logic [NUM_REQ-1:0]   w_done_next;
  logic                 w_busy_next;
  logic                 w_start_next;
  logic [7:0]           w_data_tx_next;

  // Arbitration helpers
  logic [2*NUM_REQ-1:0] w_req_dbl;
  logic [NUM_REQ-1:0]   w_req_rot;
  logic                 w_sel_valid;
  logic [PTR_W-1:0]     w_off;
  logic [PTR_W:0]       w_sum;
  logic [PTR_W-1:0]     w_sel;
  logic [PTR_W-1:0]     w_rr_after;
  logic [NUM_REQ-1:0]   w_sel_oh;
  logic [NUM_REQ-1:0]   w_owner_oh;
  logic [15:0]          w_msg [NUM_REQ];

  // Byte sequencing helpers
  logic [7:0]           w_cur_byte;
  logic [1:0]           w_last_idx;

  assign grant    = r_grant;
  assign done     = r_done;
  assign busy     = r_busy;
  assign start_tx = r_start;
  assign data_tx  = r_data_tx;

  // Rotate the request vector so that bit 0 is the requester at rr_ptr.
  assign w_req_dbl = {req, req} >> r_rr_ptr;
  assign w_req_rot = w_req_dbl[NUM_REQ-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_per_req
      assign w_msg[gi]      = req_data[16*gi +: 16];
      assign w_sel_oh[gi]   = (w_sel == PTR_W'(gi));
      assign w_owner_oh[gi] = (r_owner == PTR_W'(gi));
    end
  endgenerate

  // Lowest set bit of the rotated vector is the first requester at or after rr_ptr.
  always_comb begin
    w_sel_valid = 1'b0;
    w_off       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (w_req_rot[k]) begin
        w_sel_valid = 1'b1;
        w_off       = PTR_W'(k);
      end
    end
  end

  // Map the rotated offset back to an absolute index and derive the next pointer.
  always_comb begin
    w_sum      = {1'b0, r_rr_ptr} + {1'b0, w_off};
    w_sel      = (w_sum >= NUM_REQ_W) ? PTR_W'(w_sum - NUM_REQ_W) : PTR_W'(w_sum);
    w_rr_after = (w_sel == LAST_PTR) ? '0 : w_sel + 1'b1;
  end

  // Byte presented to the uart for the current index, and the index of the final byte.
`ifdef TX_FRAME_EN
  always_comb begin
    w_last_idx = r_two ? 2'd2 : 2'd1;
    case (r_idx)
      2'd0:    w_cur_byte = 8'h30 + 8'(r_owner);
      2'd1:    w_cur_byte = r_msg[7:0];
      default: w_cur_byte = r_msg[15:8];
    endcase
  end
`else
  always_comb begin
    w_last_idx = r_two ? 2'd1 : 2'd0;
    w_cur_byte = (r_idx == 2'd0) ? r_msg[7:0] : r_msg[15:8];
  end
`endif

  // Next-state and registered-output decode.
  always_comb begin
    w_state_next   = r_state;
    w_rr_ptr_next  = r_rr_ptr;
    w_owner_next   = r_owner;
    w_msg_next     = r_msg;
    w_two_next     = r_two;
    w_idx_next     = r_idx;
    w_grant_next   = '0;
    w_done_next    = '0;
    w_busy_next    = r_busy;
    w_start_next   = 1'b0;
    w_data_tx_next = 8'h00;

    case (r_state)
      IDLE: begin
        // busy drops here, one cycle after the done pulse
        w_busy_next = 1'b0;
        if (w_sel_valid) begin
          w_owner_next  = w_sel;
          w_msg_next    = w_msg[w_sel];
          w_two_next    = req_two_byte[w_sel];
          w_idx_next    = 2'd0;
          w_grant_next  = w_sel_oh;
          w_busy_next   = 1'b1;
          w_rr_ptr_next = w_rr_after;
          w_state_next  = SEND;
        end
      end
      SEND: begin
        if (idle_ready_tx) begin
          w_start_next   = 1'b1;
          w_data_tx_next = w_cur_byte;
          w_state_next   = BUF;
        end
      end
      BUF: begin
        // The uart still shows ready during this cycle, so it is never sampled here.
        if (r_idx != w_last_idx) begin
          w_idx_next   = r_idx + 2'd1;
          w_state_next = SEND;
        end else begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        w_done_next  = w_owner_oh;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State and output registers; reset abandons any message in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_rr_ptr  <= '0;
      r_owner   <= '0;
      r_msg     <= '0;
      r_two     <= 1'b0;
      r_idx     <= 2'd0;
      r_grant   <= '0;
      r_done    <= '0;
      r_busy    <= 1'b0;
      r_start   <= 1'b0;
      r_data_tx <= 8'h00;
    end else begin
      r_state   <= w_state_next;
      r_rr_ptr  <= w_rr_ptr_next;
      r_owner   <= w_owner_next;
      r_msg     <= w_msg_next;
      r_two     <= w_two_next;
      r_idx     <= w_idx_next;
      r_grant   <= w_grant_next;
      r_done    <= w_done_next;
      r_busy    <= w_busy_next;
      r_start   <= w_start_next;
      r_data_tx <= w_data_tx_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios followed by randomized
// requesters and uart back-pressure. A monitor keeps a cycle-level reference
// model (round-robin pointer, queue of expected uart bytes, expected done
// owner) and compares every DUT output on each falling edge.

module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     req_two_byte = '0;
  logic [16*N-1:0]  req_data = '0;
  logic             idle_ready_tx = 1'b1;
  logic [N-1:0]     grant;
  logic [N-1:0]     done;
  logic             busy;
  logic             start_tx;
  logic [7:0]       data_tx;

  logic             hold_busy = 1'b0;

  int checks   = 0;
  int failures = 0;

  uart_tx_arbiter #(.NUM_REQ(N), .PTR_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_two_byte  (req_two_byte),
    .req_data      (req_data),
    .idle_ready_tx (idle_ready_tx),
    .grant         (grant),
    .done          (done),
    .busy          (busy),
    .start_tx      (start_tx),
    .data_tx       (data_tx)
  );

  initial forever #5 clk = ~clk;

  // ---------------- reference model / scoreboard ----------------
  int          cyc       = 0;
  int          m_rr      = 0;
  int          m_owner   = 0;
  bit          m_free    = 1'b1;
  bit          m_wait    = 1'b0;
  bit          m_buf     = 1'b0;
  bit          m_ddue    = 1'b0;
  bit          m_busy    = 1'b0;
  bit          m_pdone   = 1'b0;
  int          uart_cnt  = 0;
  logic [7:0]  exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [N-1:0] exp_grant;
    logic [N-1:0] exp_done;
    bit           exp_start;
    bit           exp_busy;
    logic [7:0]   exp_byte;
    logic [15:0]  word;
    bit           found;
    int           j;
    bit           n_wait, n_ddue, n_free;

    cyc++;
    if (rst) begin
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_start", 32'(start_tx), 32'd0);
      chk("rst_data", 32'(data_tx), 32'd0);
      m_rr = 0; m_free = 1'b1; m_wait = 1'b0; m_buf = 1'b0;
      m_ddue = 1'b0; m_busy = 1'b0; m_pdone = 1'b0;
      exp_q.delete();
    end else begin
      // arbitration: first requesting index scanning upward from the pointer
      exp_grant = '0;
      found = 1'b0;
      if (m_free) begin
        for (int k = 0; k < N; k++) begin
          j = (m_rr + k) % N;
          if (!found && req[j]) begin
            found = 1'b1;
            m_owner = j;
          end
        end
      end
      if (found) begin
        exp_grant = N'(1 << m_owner);
        m_rr = (m_owner + 1) % N;
        word = 16'(req_data >> (16 * m_owner));
`ifdef TX_FRAME_EN
        exp_q.push_back(8'(8'h30 + m_owner));
`endif
        exp_q.push_back(word[7:0]);
        if (req_two_byte[m_owner]) exp_q.push_back(word[15:8]);
        $display("grant cyc=%0d req=%0d data=%04h two=%0d", cyc, m_owner, word, req_two_byte[m_owner]);
      end
      chk("grant", 32'(grant), 32'(exp_grant));

      // a byte goes out the cycle after the uart is seen ready while waiting
      exp_start = m_wait && idle_ready_tx;
      chk("start_tx", 32'(start_tx), 32'(exp_start));
      exp_byte = 8'h00;
      if (exp_start && exp_q.size() > 0) exp_byte = exp_q.pop_front();
      chk("data_tx", 32'(data_tx), 32'(exp_byte));
      if (start_tx) $display("tx byte cyc=%0d data=%02h", cyc, data_tx);

      exp_done = m_ddue ? N'(1 << m_owner) : '0;
      chk("done", 32'(done), 32'(exp_done));

      exp_busy = (exp_grant != 0) || (m_busy && !m_pdone);
      chk("busy", 32'(busy), 32'(exp_busy));

      n_wait = (m_wait && !idle_ready_tx) || (m_buf && exp_q.size() > 0) || (exp_grant != 0);
      n_ddue = m_buf && (exp_q.size() == 0);
      n_free = m_ddue || (m_free && exp_grant == 0);
      m_pdone = m_ddue;
      m_buf   = exp_start;
      m_wait  = n_wait;
      m_ddue  = n_ddue;
      m_free  = n_free;
      m_busy  = exp_busy;
    end

    // uart: busy for a random time after each accepted byte
    if (uart_cnt > 0) uart_cnt--;
    if (start_tx) uart_cnt = $urandom_range(1, 8);
    idle_ready_tx = (uart_cnt == 0) && !hold_busy;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_msg(input int i, input logic [15:0] d, input logic two);
    req_data[16*i +: 16] = d;
    req_two_byte[i] = two;
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;

    // all four requesters held with 1-byte messages: round-robin rotation
    for (int i = 0; i < N; i++) set_msg(i, 16'($urandom), 1'b0);
    req = 4'b1111;
    repeat (40) begin
      step();
      for (int i = 0; i < N; i++) if (grant[i]) set_msg(i, 16'($urandom), 1'b0);
    end
    req = '0;
    repeat (30) step();

    // requester 0, 2-byte 16'h09F6 -> bytes F6 then 09
    set_msg(0, 16'h09F6, 1'b1);
    req = 4'b0001;
    step();
    req = '0;
    set_msg(0, 16'hDEAD, 1'b0);
    repeat (30) step();

    // requester 3, 1-byte 8'h23 (header 8'h33 first when framing is built in)
    set_msg(3, 16'h5A23, 1'b0);
    req = 4'b1000;
    step();
    req = '0;
    repeat (20) step();

    // uart held not-ready for 20 cycles after grant
    hold_busy = 1'b1;
    set_msg(1, 16'($urandom), 1'b1);
    req = 4'b0010;
    step();
    req = '0;
    repeat (20) step();
    hold_busy = 1'b0;
    repeat (30) step();

    // requester 2 pulses req for one cycle while requester 0 is served
    set_msg(0, 16'($urandom), 1'b1);
    req = 4'b0001;
    step();
    req = '0;
    step();
    req[2] = 1'b1;
    step();
    req[2] = 1'b0;
    repeat (30) step();

    // reset one cycle after the first byte of a 2-byte message
    set_msg(1, 16'($urandom), 1'b1);
    req = 4'b0010;
    step();
    req = '0;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (15) step();
    // pointer restarts at 0, so requester 1 wins over requester 3
    set_msg(1, 16'($urandom), 1'b0);
    set_msg(3, 16'($urandom), 1'b1);
    req = 4'b1010;
    repeat (40) begin
      step();
      for (int i = 0; i < N; i++) if (grant[i]) req[i] = 1'b0;
    end

    // randomized requesters and uart stalls
    repeat (3000) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (grant[i]) begin
          req[i] = 1'b0;
          set_msg(i, 16'($urandom), 1'($urandom_range(0, 1)));
        end else if (!req[i] && $urandom_range(0, 5) == 0) begin
          set_msg(i, 16'($urandom), 1'($urandom_range(0, 1)));
          req[i] = 1'b1;
        end else if (req[i] && $urandom_range(0, 59) == 0) begin
          req[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 19) == 0) hold_busy = !hold_busy;
    end
    req = '0;
    hold_busy = 1'b0;
    repeat (60) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
